// File: rtl/bch_encoder_p8.sv
// Systematic binary BCH encoder, GF(2^13), t=8: message passthrough followed
// by 104 parity bits, DATA_W bits per beat, highest-degree coefficient first.
package bch_p8_pkg;

    localparam logic [12:0] GF_POLY = 13'h001B;

    function automatic logic [12:0] gf_mul(
        input logic [12:0] a,
        input logic [12:0] b
    );
        logic [12:0] p;
        logic [12:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) p = p ^ x;
            x = x[12] ? ((x << 1) ^ GF_POLY) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [12:0] gf_pow(input int e);
        logic [12:0] r;
        logic [12:0] base;
        r = 13'd1;
        base = 13'd2;
        for (int i = 0; i < 13; i++) begin
            if (((e >> i) & 1) != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ...
    function automatic logic [103:0] bch_gen_poly(input int t);
        logic [104:0]      g;
        logic [104:0]      ng;
        logic [13:0][12:0] mp;
        logic [12:0]       r;
        int                c;
        g = 105'd1;
        for (int i = 1; i < 2 * t; i += 2) begin
            mp = '0;
            mp[0] = 13'd1;
            c = i;
            for (int j = 0; j < 13; j++) begin
                r = gf_pow(c);
                for (int k = 13; k > 0; k--) begin
                    mp[k] = mp[k-1] ^ gf_mul(mp[k], r);
                end
                mp[0] = gf_mul(mp[0], r);
                c = (c * 2) % 8191;
            end
            ng = '0;
            for (int k = 0; k < 14; k++) begin
                if (mp[k][0]) ng = ng ^ (g << k);
            end
            g = ng;
        end
        return g[103:0];
    endfunction

    localparam logic [103:0] BCH_GEN_T8 = bch_gen_poly(8);

endpackage

module bch_encoder_p8
    import bch_p8_pkg::*;
#(
    parameter int              M        = 13,
    parameter int              T        = 8,
    parameter int              DATA_W   = 8,
    parameter int              K_BEATS  = 512,
    parameter logic [M*T-1:0]  GEN_POLY = BCH_GEN_T8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    localparam int PAR_W     = M * T;
    localparam int PAR_BEATS = PAR_W / DATA_W;
    localparam int CNT_MAX   = (K_BEATS > PAR_BEATS) ? K_BEATS : PAR_BEATS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PAR_W-1:0]   lfsr_q;
    logic [PAR_W-1:0]   lfsr_d;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_valid_q;
    logic               out_first_q;
    logic               out_last_q;
    logic               busy_q;
    logic               fb;
    logic               accept;

    assign in_ready  = (state_q != PAR);
    assign accept    = in_valid & in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    // Serial division step unrolled over the beat, MSB first.
    always_comb begin
        lfsr_d = lfsr_q;
        fb = 1'b0;
        for (int b = DATA_W - 1; b >= 0; b--) begin
            fb = in_data[b] ^ lfsr_d[PAR_W-1];
            lfsr_d = {lfsr_d[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lfsr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) busy_q <= 1'b0;
            unique case (state_q)
                IDLE, MSG: begin
                    if (accept) begin
                        out_data_q  <= in_data;
                        out_valid_q <= 1'b1;
                        lfsr_q      <= lfsr_d;
                        if (state_q == IDLE) begin
                            out_first_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                        if (cnt_q == CNT_W'(K_BEATS - 1)) begin
                            state_q <= PAR;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= MSG;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                PAR: begin
                    out_data_q  <= lfsr_q[PAR_W-1 -: DATA_W];
                    out_valid_q <= 1'b1;
                    if (cnt_q == CNT_W'(PAR_BEATS - 1)) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        lfsr_q     <= '0;
                        out_last_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        lfsr_q <= lfsr_q << DATA_W;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_encoder_p8.sv
// Directed bench for bch_encoder_p8: framing, latency, and parity checked
// through GF(2^13) syndromes S1..S16 of each emitted codeword.
module tb_bch_encoder_p8;

    localparam int K    = 512;
    localparam int NPAR = 13;
    localparam int NB   = K + NPAR;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic       busy;

    bch_encoder_p8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       b;
        int         stamp;
    } beat_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         nlast = 0;
    int         rdy_low = 0;
    beat_t      oq[$];
    int         acc_q[$];
    logic [7:0] msg [0:1023];
    logic [12:0] apow [1:16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t bt;
        if (out_valid) begin
            bt.d = out_data;
            bt.f = out_first;
            bt.l = out_last;
            bt.b = busy;
            bt.stamp = cyc;
            oq.push_back(bt);
            if (out_last) nlast++;
        end
        if (!in_ready) rdy_low++;
    end

    function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
        logic [12:0] p;
        logic [12:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) p = p ^ x;
            x = x[12] ? ((x << 1) ^ 13'h001B) : (x << 1);
        end
        return p;
    endfunction

    function automatic int syn_bad(input int base);
        logic [12:0] s [1:16];
        int n;
        n = 0;
        for (int j = 1; j <= 16; j++) s[j] = '0;
        for (int k = 0; k < NB; k++) begin
            for (int b = 7; b >= 0; b--) begin
                for (int j = 1; j <= 16; j++) begin
                    s[j] = gmul(s[j], apow[j]) ^ {12'd0, oq[base+k].d[b]};
                end
            end
        end
        for (int j = 1; j <= 16; j++) if (s[j] != 0) n++;
        return n;
    endfunction

    function automatic int cnt_echo(input int base, input int moff);
        int n;
        n = 0;
        for (int k = 0; k < K; k++) if (oq[base+k].d !== msg[moff+k]) n++;
        return n;
    endfunction

    function automatic int cnt_lat(input int base, input int aoff);
        int n;
        n = 0;
        for (int k = 0; k < K; k++) if (oq[base+k].stamp != acc_q[aoff+k]) n++;
        return n;
    endfunction

    function automatic int cnt_flags(input int base);
        int n;
        n = 0;
        for (int k = 0; k < NB; k++) begin
            if (oq[base+k].f !== (k == 0)) n++;
            if (oq[base+k].l !== (k == NB - 1)) n++;
        end
        return n;
    endfunction

    task automatic clear_mon();
        oq.delete();
        acc_q.delete();
        nlast = 0;
        rdy_low = 0;
    endtask

    task automatic send(input int first, input int n, input int idle_pct);
        int i;
        int guard;
        bit v;
        i = first;
        guard = 0;
        while (i < first + n && guard < 4 * n + 100) begin
            v = ($urandom_range(99) >= idle_pct);
            in_valid = v;
            in_data = v ? msg[i] : 8'($urandom);
            if (v && in_ready) begin
                acc_q.push_back(cyc + 1);
                i++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (i < first + n) begin
            total++;
            bad++;
            $display("FAIL send_timeout: accepted %0d want %0d", i - first, n);
        end
    endtask

    task automatic wait_last(input int want);
        int g;
        g = 0;
        while (nlast < want && g < 60) begin
            @(posedge clk);
            #1;
            g++;
        end
        total++;
        if (nlast < want) begin
            bad++;
            $display("FAIL wait_last: got %0d want %0d", nlast, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total += 6;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        if (out_data !== 8'h00) begin
            bad++; $display("FAIL rst_out_data: got %h want 00", out_data);
        end
        if (out_first !== 1'b0) begin
            bad++; $display("FAIL rst_out_first: got %b want 0", out_first);
        end
        if (out_last !== 1'b0) begin
            bad++; $display("FAIL rst_out_last: got %b want 0", out_last);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_zero_msg();
        int nz;
        for (int k = 0; k < K; k++) msg[k] = 8'h00;
        clear_mon();
        send(0, K, 0);
        wait_last(1);
        total++;
        if (oq.size() != NB) begin
            bad++; $display("FAIL zero_count: got %0d want %0d", oq.size(), NB);
        end else begin
            nz = 0;
            for (int k = 0; k < NB; k++) if (oq[k].d !== 8'h00) nz++;
            total += 5;
            if (nz != 0) begin
                bad++; $display("FAIL zero_data: nonzero beats %0d want 0", nz);
            end
            if (cnt_flags(0) != 0) begin
                bad++; $display("FAIL zero_flags: errs %0d want 0", cnt_flags(0));
            end
            if (cnt_lat(0, 0) != 0) begin
                bad++; $display("FAIL zero_latency: errs %0d want 0", cnt_lat(0, 0));
            end
            if (oq[0].b !== 1'b1 || oq[NB-1].b !== 1'b1) begin
                bad++;
                $display("FAIL zero_busy_span: first %b last %b want 1 1",
                         oq[0].b, oq[NB-1].b);
            end
            if (rdy_low != NPAR) begin
                bad++; $display("FAIL zero_ready_low: got %0d want %0d", rdy_low, NPAR);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL zero_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_unit_msg();
        int sb;
        for (int k = 0; k < K; k++) msg[k] = 8'h00;
        msg[K-1] = 8'h01;
        clear_mon();
        send(0, K, 0);
        wait_last(1);
        total++;
        if (oq.size() != NB) begin
            bad++; $display("FAIL unit_count: got %0d want %0d", oq.size(), NB);
        end else begin
            sb = syn_bad(0);
            total += 3;
            if (sb != 0) begin
                bad++; $display("FAIL unit_syndrome: nonzero %0d want 0", sb);
            end
            if (oq[NB-1].d[0] !== 1'b1) begin
                bad++; $display("FAIL unit_g0: got %b want 1", oq[NB-1].d[0]);
            end
            if (oq[K-1].d !== 8'h01) begin
                bad++; $display("FAIL unit_echo: got %h want 01", oq[K-1].d);
            end
        end
    endtask

    task automatic test_gaps();
        int sb;
        for (int k = 0; k < K; k++) msg[k] = 8'($urandom);
        clear_mon();
        send(0, K, 30);
        wait_last(1);
        total++;
        if (oq.size() != NB) begin
            bad++; $display("FAIL gap_count: got %0d want %0d", oq.size(), NB);
        end else begin
            sb = syn_bad(0);
            total += 4;
            if (cnt_echo(0, 0) != 0) begin
                bad++; $display("FAIL gap_echo: errs %0d want 0", cnt_echo(0, 0));
            end
            if (cnt_lat(0, 0) != 0) begin
                bad++; $display("FAIL gap_latency: errs %0d want 0", cnt_lat(0, 0));
            end
            if (cnt_flags(0) != 0) begin
                bad++; $display("FAIL gap_flags: errs %0d want 0", cnt_flags(0));
            end
            if (sb != 0) begin
                bad++; $display("FAIL gap_syndrome: nonzero %0d want 0", sb);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sb;
        for (int k = 0; k < K; k++) msg[k] = 8'($urandom);
        clear_mon();
        send(0, 200, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_mon();
        total += 2;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mid_busy: got %b want 0", busy);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (oq.size() != 0) begin
            bad++; $display("FAIL mid_quiet: beats %0d want 0", oq.size());
        end
        for (int k = 0; k < K; k++) msg[k] = 8'($urandom);
        send(0, K, 10);
        wait_last(1);
        total++;
        if (oq.size() != NB) begin
            bad++; $display("FAIL mid_count: got %0d want %0d", oq.size(), NB);
        end else begin
            sb = syn_bad(0);
            total += 3;
            if (cnt_flags(0) != 0) begin
                bad++; $display("FAIL mid_flags: errs %0d want 0", cnt_flags(0));
            end
            if (cnt_echo(0, 0) != 0) begin
                bad++; $display("FAIL mid_echo: errs %0d want 0", cnt_echo(0, 0));
            end
            if (sb != 0) begin
                bad++; $display("FAIL mid_syndrome: nonzero %0d want 0", sb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int s1;
        for (int k = 0; k < 2 * K; k++) msg[k] = 8'($urandom);
        clear_mon();
        send(0, 2 * K, 0);
        wait_last(2);
        total++;
        if (oq.size() != 2 * NB) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", oq.size(), 2 * NB);
        end else begin
            s0 = syn_bad(0);
            s1 = syn_bad(NB);
            total += 7;
            if (oq[NB].stamp != oq[NB-1].stamp + 1) begin
                bad++;
                $display("FAIL b2b_gap: first2 at %0d want %0d",
                         oq[NB].stamp, oq[NB-1].stamp + 1);
            end
            if (cnt_flags(0) + cnt_flags(NB) != 0) begin
                bad++;
                $display("FAIL b2b_flags: errs %0d want 0",
                         cnt_flags(0) + cnt_flags(NB));
            end
            if (cnt_echo(0, 0) + cnt_echo(NB, K) != 0) begin
                bad++;
                $display("FAIL b2b_echo: errs %0d want 0",
                         cnt_echo(0, 0) + cnt_echo(NB, K));
            end
            if (cnt_lat(0, 0) + cnt_lat(NB, K) != 0) begin
                bad++;
                $display("FAIL b2b_latency: errs %0d want 0",
                         cnt_lat(0, 0) + cnt_lat(NB, K));
            end
            if (s0 != 0 || s1 != 0) begin
                bad++; $display("FAIL b2b_syndrome: nonzero %0d %0d want 0 0", s0, s1);
            end
            if (oq[NB].b !== 1'b1) begin
                bad++; $display("FAIL b2b_busy: got %b want 1", oq[NB].b);
            end
            if (rdy_low != 2 * NPAR) begin
                bad++;
                $display("FAIL b2b_ready_low: got %0d want %0d", rdy_low, 2 * NPAR);
            end
        end
    endtask

    initial begin
        apow[1] = 13'd2;
        for (int j = 2; j <= 16; j++) apow[j] = gmul(apow[j-1], 13'd2);
        test_reset();
        test_zero_msg();
        test_unit_msg();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bch_encoder_p8.md
Name: bch_encoder_p8

Overview:
- Systematic binary BCH encoder over GF(2^13), t=8, producing 104 parity bits per codeword.
- This is the transmit-side counterpart of correct_module_4cells_p16: codewords it emits must yield all-zero syndromes at the decoder's front end.
- Message enters DATA_W bits/cycle, MSB (highest-degree coefficient) first.
- Output is the message passed through, followed by the parity, on the same bus width.

Parameters:
- M, 13, Galois field degree.
- T, 8, correctable errors; PAR_W = M*T = 104 parity bits.
- DATA_W, 8, bits per beat; must divide PAR_W (104/8 = 13 parity beats).
- K_BEATS, 512, message beats per codeword (4096 message bits; n = 4200 ≤ 8191, shortened code).
- GEN_POLY, BCH_GEN_T8 from the shared BCH parameter header, PAR_W bits: coefficients g0..g103 of the monic generator g(x). The x^104 term is implicit; bit i = g_i.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_W  message beat; bit DATA_W-1 is the highest-degree bit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a message beat this cycle.
- out_data  out  DATA_W  codeword beat.
- out_valid  out  1  out_data valid.
- out_first  out  1  first beat of a codeword.
- out_last  out  1  last parity beat of a codeword.
- busy  out  1  high from first accepted beat until the last parity beat is emitted.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_first=0, out_last=0, busy=0, LFSR=0, beat counter=0, state=IDLE. in_ready=1 in the cycle after reset deasserts.
- Reset mid-codeword aborts immediately; no partial parity is emitted.
- States: IDLE, MSG, PAR.
  - IDLE: in_ready=1. An accepted beat (in_valid & in_ready) moves to MSG with counter=1, or directly to PAR if K_BEATS=1.
  - MSG: in_ready=1. Each accepted beat increments the counter. The beat that makes counter==K_BEATS moves to PAR.
  - PAR: in_ready=0. Emits one parity beat per cycle, PAR_W/DATA_W beats, with no stall. After the last beat: IDLE.
- LFSR update per accepted beat: the serial step is unrolled DATA_W times combinationally, MSB first.
  - For each bit b: fb = b ^ r[PAR_W-1]; r = (r<<1) ^ (fb ? GEN_POLY : 0).
  - This computes r = m(x)·x^104 mod g(x).
- Message passthrough:
  - out_data = in_data, registered, 1-cycle latency.
  - out_valid is asserted one cycle after each accepted beat.
  - Gaps in in_valid produce gaps in out_valid. The LFSR holds during a gap.
- Parity emission:
  - Each PAR beat outputs r[PAR_W-1 -: DATA_W], then r <<= DATA_W.
  - Highest-degree parity is emitted first, registered, with out_valid=1.
  - The first parity beat follows the last message output beat with no bubble.
- LFSR clear: cleared to 0 on the last PAR beat, ready for the next codeword.
- out_first and out_last:
  - out_first=1 with the output of the first message beat only.
  - out_last=1 with the final parity beat only.
- Back-to-back codewords: IDLE accepts a new beat the cycle after PAR ends. Max throughput is K_BEATS+13 cycles per codeword.
- No output backpressure; the downstream consumer must take every valid beat.
- busy=1 from the cycle after the first accepted beat through the cycle out_last is high.
- in_data is ignored whenever in_ready=0 or in_valid=0.

Test Plan:
- All-zero message, in_valid held high for 512 beats -> 525 out_valid beats, all out_data=0. out_first on beat 1, out_last on beat 525, in_ready low for exactly 13 cycles.
- Message all zero except in_data=8'h01 on beat 512 -> the 13 parity beats concatenated equal GEN_POLY (104 bits, MSB first), since x^104 mod g = g − x^104.
- Random message with random in_valid gaps (≈30% idle) -> message echoes in order at 1-cycle latency. Parity matches the software LFSR model. The codeword fed to the GF(2^13) syndrome model gives S1..S16 = 0.
- Same codeword with 1–8 random bit flips, fed to correct_module_4cells_p16 -> decoder reports error_number equal to the flip count and the corrected locations match.
- Reset asserted at message beat 200 for one cycle, then a fresh 512-beat message -> no out_valid after reset until the new first beat. out_first is high on the new first beat and parity matches the new message alone.
- Two codewords back to back with in_valid continuously high -> second out_first occurs exactly 1 cycle after the first out_last, and both parities are correct.
